// File: rtl/encode_scheduler.sv
// encode_scheduler: shares one 8b10b encoder between N_REQ byte requesters.
// Every sym_strobe is one symbol slot. After enable the link sends a burst of
// sync commas, then repeating frames of one comma slot followed by data slots.
// Data slots are arbitrated round-robin with a per-owner burst limit.
// All decisions are registered, so they appear one bitclk after the strobe.
module encode_scheduler #(
   parameter int         N_REQ       = 4,
   parameter logic [8:0] COMMA_CHAR  = 9'h13C,
   parameter logic [8:0] IDLE_CHAR   = 9'h11C,
   parameter int         FRAME_LEN   = 9,
   parameter int         MAX_BURST   = 8,
   parameter int         SYNC_COMMAS = 4
) (
   input  logic                 bitclk,
   input  logic                 reset_bitclk,
   input  logic                 enable,
   input  logic [N_REQ-1:0]     req_mask,
   input  logic                 sym_strobe,
   input  logic [N_REQ-1:0]     req,
   input  logic [8*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]     gnt,
   output logic [8:0]           enc_data,
   output logic                 enc_valid,
   output logic [1:0]           state,
   output logic [15:0]          frame_cnt
);

   localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   // Slot, burst and sync counters are 8 bits wide: FRAME_LEN and MAX_BURST
   // are limited to 255, and SYNC_COMMAS is expected to stay below 256.
   localparam logic [7:0]    LAST_SLOT = 8'(FRAME_LEN - 1);
   localparam logic [7:0]    MAX_B     = 8'(MAX_BURST);
   localparam logic [7:0]    SYNC_N    = 8'(SYNC_COMMAS);
   localparam logic [OW-1:0] LAST_REQ  = OW'(N_REQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [8:0]        enc_data_q, enc_data_d;
   logic              enc_valid_q, enc_valid_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic [7:0]        slot_q, slot_d;
   logic [7:0]        burst_q, burst_d;
   logic [OW-1:0]     owner_q, owner_d;
   logic [7:0]        sync_cnt_q, sync_cnt_d;

   // Arbitration and slot bookkeeping signals
   logic [N_REQ-1:0]  elig;
   logic              any_elig;
   logic              keep_owner;
   logic              found;
   logic [OW-1:0]     cand;
   logic [OW-1:0]     pick;
   logic [OW-1:0]     winner;
   logic [7:0]        win_byte;
   logic              sync_done;
   logic              frame_start;
   logic [7:0]        next_slot;

   // State and datapath registers; reset is asynchronous and clears everything
   always_ff @(posedge bitclk or posedge reset_bitclk) begin
      if (reset_bitclk) begin
         state_q     <= ST_IDLE;
         enc_data_q  <= IDLE_CHAR;
         enc_valid_q <= 1'b0;
         gnt_q       <= '0;
         frame_cnt_q <= '0;
         slot_q      <= '0;
         burst_q     <= '0;
         owner_q     <= '0;
         sync_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         enc_data_q  <= enc_data_d;
         enc_valid_q <= enc_valid_d;
         gnt_q       <= gnt_d;
         frame_cnt_q <= frame_cnt_d;
         slot_q      <= slot_d;
         burst_q     <= burst_d;
         owner_q     <= owner_d;
         sync_cnt_q  <= sync_cnt_d;
      end
   end

   // Slot-level status shared by the FSM and the datapath
   always_comb begin
      sync_done   = (sync_cnt_q >= SYNC_N);
      frame_start = ((state_q == ST_SYNC) && sync_done) ||
                    ((state_q == ST_RUN) && (slot_q == 8'd0));
      next_slot   = (slot_q == LAST_SLOT) ? 8'd0 : slot_q + 8'd1;
   end

   // Next-state: move only on strobes; disable always falls back to IDLE
   always_comb begin
      state_d = state_q;
      if (sym_strobe) begin
         case (state_q)
            ST_IDLE: if (enable) state_d = ST_SYNC;
            ST_SYNC: begin
               if (!enable)        state_d = ST_IDLE;
               else if (sync_done) state_d = ST_RUN;
            end
            ST_RUN:  if (!enable) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Round-robin pick: keep the owner while it is eligible and under its
   // burst limit, otherwise take the first eligible requester after it.
   // The owner itself is the last candidate, so a lone requester whose burst
   // expired is re-selected and starts a fresh burst.
   always_comb begin
      elig       = req & ~req_mask;
      any_elig   = |elig;
      keep_owner = elig[owner_q] && (burst_q < MAX_B);
      found      = 1'b0;
      pick       = owner_q;
      cand       = owner_q;
      for (int k = 0; k < N_REQ; k++) begin
         cand = (cand == LAST_REQ) ? '0 : cand + 1'b1;
         if (!found && elig[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
      winner   = keep_owner ? owner_q : pick;
      win_byte = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (winner == OW'(j)) win_byte = req_data[j*8 +: 8];
      end
   end

   // Output and counter updates: one symbol decision per strobe
   always_comb begin
      enc_data_d  = enc_data_q;
      enc_valid_d = 1'b0;
      gnt_d       = '0;
      frame_cnt_d = frame_cnt_q;
      slot_d      = slot_q;
      burst_d     = burst_q;
      owner_d     = owner_q;
      sync_cnt_d  = sync_cnt_q;
      if (sym_strobe) begin
         enc_valid_d = 1'b1;
         enc_data_d  = IDLE_CHAR;
         if (!enable) begin
            slot_d     = '0;
            burst_d    = '0;
            owner_d    = '0;
            sync_cnt_d = '0;
         end else if (state_q == ST_IDLE) begin
            enc_data_d = COMMA_CHAR;
            sync_cnt_d = 8'd1;
         end else if ((state_q == ST_SYNC) && !sync_done) begin
            enc_data_d = COMMA_CHAR;
            sync_cnt_d = sync_cnt_q + 8'd1;
         end else if (frame_start) begin
            enc_data_d  = COMMA_CHAR;
            frame_cnt_d = frame_cnt_q + 16'd1;
            slot_d      = next_slot;
         end else if (state_q == ST_RUN) begin
            slot_d = next_slot;
            if (any_elig) begin
               enc_data_d = {1'b0, win_byte};
               gnt_d      = N_REQ'(1) << winner;
               if (keep_owner) begin
                  burst_d = burst_q + 8'd1;
               end else begin
                  owner_d = winner;
                  burst_d = 8'd1;
               end
            end
         end
      end
   end

   assign state     = state_q;
   assign enc_data  = enc_data_q;
   assign enc_valid = enc_valid_q;
   assign gnt       = gnt_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_encode_scheduler.sv
// Randomized bench for encode_scheduler against a slot-level reference model.
module tb_encode_scheduler;

   localparam int         NR    = 4;
   localparam logic [8:0] COMMA = 9'h13C;
   localparam logic [8:0] IDLE  = 9'h11C;
   localparam int         FL    = 9;
   localparam int         MB    = 2;
   localparam int         SC    = 4;

   logic              bitclk = 1'b0;
   logic              reset_bitclk = 1'b0;
   logic              enable = 1'b0;
   logic [NR-1:0]     req_mask = '0;
   logic              sym_strobe = 1'b0;
   logic [NR-1:0]     req = '0;
   logic [8*NR-1:0]   req_data = '0;
   logic [NR-1:0]     gnt;
   logic [8:0]        enc_data;
   logic              enc_valid;
   logic [1:0]        state;
   logic [15:0]       frame_cnt;

   int n_chk = 0;
   int n_bad = 0;

   // reference model state
   int          m_state, m_sync, m_slot, m_burst, m_owner;
   logic [15:0] m_frame;

   encode_scheduler #(
      .N_REQ(NR), .COMMA_CHAR(COMMA), .IDLE_CHAR(IDLE),
      .FRAME_LEN(FL), .MAX_BURST(MB), .SYNC_COMMAS(SC)
   ) dut (
      .bitclk(bitclk), .reset_bitclk(reset_bitclk), .enable(enable),
      .req_mask(req_mask), .sym_strobe(sym_strobe), .req(req),
      .req_data(req_data), .gnt(gnt), .enc_data(enc_data),
      .enc_valid(enc_valid), .state(state), .frame_cnt(frame_cnt)
   );

   always #5 bitclk = ~bitclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_sync = 0; m_slot = 0; m_burst = 0; m_owner = 0;
      m_frame = '0;
   endtask

   // One symbol slot of the scheduler, expressed directly from its rules.
   task automatic model_step(input logic en, input logic [NR-1:0] rq, input logic [NR-1:0] mk,
                             input logic [8*NR-1:0] dat,
                             output logic [8:0] e_data, output logic [NR-1:0] e_gnt);
      logic [NR-1:0] el;
      int w;
      bit hit;
      e_data = IDLE;
      e_gnt  = '0;
      if (!en) begin
         m_state = 0; m_sync = 0; m_slot = 0; m_burst = 0; m_owner = 0;
         return;
      end
      if (m_state == 0) begin
         e_data = COMMA; m_state = 1; m_sync = 1;
         return;
      end
      if (m_state == 1) begin
         if (m_sync < SC) begin
            e_data = COMMA; m_sync++;
            return;
         end
         m_state = 2; m_slot = 0;
      end
      // RUN slot
      if (m_slot == 0) begin
         e_data  = COMMA;
         m_frame = m_frame + 16'd1;
      end else begin
         el = rq & ~mk;
         if (el != 0) begin
            if (el[m_owner] && m_burst < MB) begin
               w = m_owner;
               m_burst++;
            end else begin
               hit = 0; w = m_owner;
               for (int k = 1; k <= NR; k++) begin
                  if (!hit && el[(m_owner + k) % NR]) begin
                     hit = 1; w = (m_owner + k) % NR;
                  end
               end
               m_owner = w;
               m_burst = 1;
            end
            e_data = {1'b0, dat[8*w +: 8]};
            e_gnt  = NR'(1) << w;
         end
      end
      m_slot = (m_slot + 1) % FL;
   endtask

   // Drive one strobe, check the registered decision, then idle gap-1 cycles.
   task automatic do_strobe(input logic en, input logic [NR-1:0] rq, input logic [NR-1:0] mk,
                            input logic [8*NR-1:0] dat, input int gap, input bit wiggle);
      logic [8:0]    ed;
      logic [NR-1:0] eg;
      @(negedge bitclk);
      enable = en; req = rq; req_mask = mk; req_data = dat; sym_strobe = 1'b1;
      model_step(en, rq, mk, dat, ed, eg);
      @(posedge bitclk); #1;
      sym_strobe = 1'b0;
      chk("enc_valid", {31'd0, enc_valid}, 32'd1);
      chk("enc_data", {23'd0, enc_data}, {23'd0, ed});
      chk("gnt", {28'd0, gnt}, {28'd0, eg});
      chk("state", {30'd0, state}, 32'(m_state));
      chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_frame});
      for (int g = 1; g < gap; g++) begin
         @(negedge bitclk);
         if (wiggle) begin
            req = NR'($urandom); req_mask = NR'($urandom); req_data = $urandom;
         end
         @(posedge bitclk); #1;
         chk("gap_quiet", {27'd0, enc_valid, gnt}, 32'd0);
         chk("gap_hold", {23'd0, enc_data}, {23'd0, ed});
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, {30'd0, state}, 32'd0);
      chk({tag, "_data"}, {23'd0, enc_data}, {23'd0, IDLE});
      chk({tag, "_valid"}, {31'd0, enc_valid}, 32'd0);
      chk({tag, "_gnt"}, {28'd0, gnt}, 32'd0);
      chk({tag, "_frame"}, {16'd0, frame_cnt}, 32'd0);
   endtask

   initial begin
      logic [15:0] held;
      model_reset();
      // asynchronous reset seen before any clock edge
      #1 reset_bitclk = 1'b1;
      #2 chk_reset_vals("rst0");
      #20 reset_bitclk = 1'b0;

      // sync commas, then empty frames
      for (int i = 0; i < SC + 3 * FL; i++) do_strobe(1'b1, '0, '0, '0, 10, 1'b0);
      chk("frames_after_three", {16'd0, frame_cnt}, 32'd3);

      // single requester
      for (int i = 0; i < 2 * FL; i++) do_strobe(1'b1, 4'b0001, '0, 32'h000000A5, 3, 1'b0);

      // all requesting, burst-limited rotation across comma slots
      for (int i = 0; i < 3 * FL; i++) do_strobe(1'b1, 4'b1111, '0, 32'h44332211, 2, 1'b0);

      // masked requester 0, then unmasked mid-burst
      for (int i = 0; i < 12; i++) do_strobe(1'b1, 4'b0011, 4'b0001, 32'h0000BBAA, 2, 1'b0);
      for (int i = 0; i < 10; i++) do_strobe(1'b1, 4'b0011, 4'b0000, 32'h0000BBAA, 2, 1'b0);

      // disable at RUN slot 5, then re-enable
      for (int i = 0; i < 2 * FL && !(m_state == 2 && m_slot == 5); i++)
         do_strobe(1'b1, 4'b0110, '0, 32'h00C3D200, 2, 1'b0);
      chk("pre_disable_state", {30'd0, state}, 32'd2);
      held = frame_cnt;
      do_strobe(1'b0, 4'b0110, '0, 32'h00C3D200, 3, 1'b0);
      chk("disable_frame_held", {16'd0, frame_cnt}, {16'd0, held});
      for (int i = 0; i < SC + FL + 2; i++) do_strobe(1'b1, 4'b0110, '0, 32'h00C3D200, 2, 1'b0);

      // randomized traffic with glitches between strobes
      for (int i = 0; i < 400; i++)
         do_strobe(($urandom_range(0, 39) != 0), NR'($urandom), NR'($urandom_range(0, 3) == 0 ? $urandom : 0),
                   $urandom, $urandom_range(2, 6), 1'b1);

      // make sure the next reset lands mid-frame with visible non-reset outputs
      for (int i = 0; i < 30 && !(m_state == 2 && m_slot == 4); i++)
         do_strobe(1'b1, 4'b1010, '0, 32'h77665544, 2, 1'b0);
      do_strobe(1'b1, 4'b1010, '0, 32'h77665544, 2, 1'b0);
      @(negedge bitclk);
      #2 reset_bitclk = 1'b1;
      #1 chk_reset_vals("rst_mid");
      model_reset();
      #13 reset_bitclk = 1'b0;
      for (int i = 0; i < SC + FL + 3; i++) do_strobe(1'b1, NR'($urandom), '0, $urandom, 3, 1'b0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
